// File: rtl/mux2_rr_arbiter.sv
// Two-channel round-robin arbiter driving the select of a 2-to-1 mux, with burst capping.
// Optional per-channel transfer statistics are built when MUX2_RR_ARBITER_STATS_EN is defined.
module mux2_rr_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic        b_valid,
    output logic        b_ready,
    output logic        sel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  owner,
    output logic [15:0] xfer_cnt_a,
    output logic [15:0] xfer_cnt_b
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_A = 2'b01,
        OWN_B = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    state_t           state, state_nxt;
    logic             sel_nxt;
    logic [CNT_W-1:0] burst_cnt, burst_nxt;
    logic             ptr, ptr_nxt;     // 0: A wins a tie in IDLE, 1: B wins
    logic             rel_a, rel_b;

    function automatic logic [CNT_W-1:0] burst_inc(input logic [CNT_W-1:0] c);
        return (c >= BURST_MAX) ? BURST_MAX : c + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= 1'b0;
            burst_cnt <= '0;
            ptr       <= 1'b0;
        end else begin
            state     <= state_nxt;
            sel       <= sel_nxt;
            burst_cnt <= burst_nxt;
            ptr       <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        burst_nxt = burst_cnt;
        ptr_nxt   = ptr;
        rel_a     = 1'b0;
        rel_b     = 1'b0;
        case (state)
            IDLE: begin
                if (a_valid && (!b_valid || !ptr)) begin
                    state_nxt = OWN_A;
                    sel_nxt   = 1'b0;
                    burst_nxt = '0;
                end else if (b_valid) begin
                    state_nxt = OWN_B;
                    sel_nxt   = 1'b1;
                    burst_nxt = '0;
                end
            end
            OWN_A: begin
                // A stall (valid & !ready) falls through with everything held
                if (!a_valid) begin
                    rel_a = 1'b1;
                end else if (out_ready) begin
                    burst_nxt = burst_inc(burst_cnt);
                    rel_a     = b_valid && (burst_nxt == BURST_MAX);
                end
            end
            OWN_B: begin
                if (!b_valid) begin
                    rel_b = 1'b1;
                end else if (out_ready) begin
                    burst_nxt = burst_inc(burst_cnt);
                    rel_b     = a_valid && (burst_nxt == BURST_MAX);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (rel_a) begin
            ptr_nxt   = 1'b1;
            burst_nxt = '0;
            if (b_valid) begin
                state_nxt = OWN_B;
                sel_nxt   = 1'b1;
            end else begin
                state_nxt = IDLE;
            end
        end else if (rel_b) begin
            ptr_nxt   = 1'b0;
            burst_nxt = '0;
            if (a_valid) begin
                state_nxt = OWN_A;
                sel_nxt   = 1'b0;
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    always_comb begin
        out_valid = ((state == OWN_A) && a_valid) || ((state == OWN_B) && b_valid);
        a_ready   = (state == OWN_A) && out_ready;
        b_ready   = (state == OWN_B) && out_ready;
        owner     = state;
    end

`ifdef MUX2_RR_ARBITER_STATS_EN
    logic xfer_a, xfer_b;

    function automatic logic [15:0] stat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    assign xfer_a = (state == OWN_A) && a_valid && out_ready;
    assign xfer_b = (state == OWN_B) && b_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt_a <= 16'h0000;
            xfer_cnt_b <= 16'h0000;
        end else begin
            if (xfer_a) xfer_cnt_a <= stat_inc(xfer_cnt_a);
            if (xfer_b) xfer_cnt_b <= stat_inc(xfer_cnt_b);
        end
    end
`else
    assign xfer_cnt_a = 16'h0000;
    assign xfer_cnt_b = 16'h0000;
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Self-checking bench for mux2_rr_arbiter: a scoreboard of expected sel values per accepted transfer.
module tb_mux2_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, b_valid, out_ready;
    logic        a_ready, b_ready, sel, out_valid;
    logic [1:0]  owner;
    logic [15:0] xfer_cnt_a, xfer_cnt_b;

    int checks = 0;
    int errors = 0;
    int n_a = 0;
    int n_b = 0;
    logic exp_q[$];

`ifdef MUX2_RR_ARBITER_STATS_EN
    localparam logic [15:0] EXP_STAT = 16'd12;
`else
    localparam logic [15:0] EXP_STAT = 16'd0;
`endif

    mux2_rr_arbiter #(.MAX_BURST(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready),
        .b_valid(b_valid), .b_ready(b_ready),
        .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
        .owner(owner), .xfer_cnt_a(xfer_cnt_a), .xfer_cnt_b(xfer_cnt_b)
    );

    always #5 clk = ~clk;

    // Scoreboard: every accepted transfer pops the expected select
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            logic exp_sel;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_xfer: got sel=%0b, required no transfer", sel);
            end else begin
                exp_sel = exp_q.pop_front();
                if (sel !== exp_sel || a_ready !== !exp_sel || b_ready !== exp_sel) begin
                    errors++;
                    $display("FAIL xfer_sel: got sel=%0b a_ready=%0b b_ready=%0b, required sel=%0b",
                             sel, a_ready, b_ready, exp_sel);
                end
            end
            if (a_ready && a_valid) n_a++;
            if (b_ready && b_valid) n_b++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1; rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (sel !== 1'b0 || owner !== 2'b00 || out_valid !== 1'b0 || a_ready !== 1'b0 ||
                b_ready !== 1'b0 || xfer_cnt_a !== 16'h0 || xfer_cnt_b !== 16'h0) begin
                errors++;
                $display("FAIL reset_state: got sel=%0b owner=%0b out_valid=%0b a_ready=%0b b_ready=%0b cnt=%0h/%0h, required all 0",
                         sel, owner, out_valid, a_ready, b_ready, xfer_cnt_a, xfer_cnt_b);
            end
            next_cycle();
        end
        rst_n = 1'b1;
        exp_q.push_back(1'b0);
        @(negedge clk);
        checks++;
        if (owner !== 2'b00 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got owner=%0b out_valid=%0b, required 00/0", owner, out_valid);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (owner !== 2'b01 || sel !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL first_grant: got owner=%0b sel=%0b out_valid=%0b, required 01/0/1", owner, sel, out_valid);
        end
        next_cycle();
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    task automatic test_single_owner();
        int start_a;
        do_reset();
        start_a = n_a;
        a_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) exp_q.push_back(1'b0);
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (owner !== 2'b01 || sel !== 1'b0) begin
                    errors++;
                    $display("FAIL single_owner_hold: cycle %0d got owner=%0b sel=%0b, required 01/0", i, owner, sel);
                end
            end
            next_cycle();
        end
        a_valid = 1'b0;
        checks++;
        if (exp_q.size() != 0 || n_a - start_a != 10) begin
            errors++;
            $display("FAIL single_owner_count: got %0d transfers, %0d pending, required 10/0", n_a - start_a, exp_q.size());
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 12; i++) exp_q.push_back(((i / 4) % 2) == 1);
        for (int i = 0; i <= 12; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL rr_no_bubble: cycle %0d got out_valid=%0b, required 1", i, out_valid);
                end
            end
            next_cycle();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rr_pending: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_stall();
        do_reset();
        a_valid = 1'b1; out_ready = 1'b1;
        exp_q.push_back(1'b0); exp_q.push_back(1'b0);
        for (int i = 0; i < 3; i++) next_cycle();
        b_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (owner !== 2'b01 || sel !== 1'b0 || a_ready !== 1'b0 || b_ready !== 1'b0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold: cycle %0d got owner=%0b sel=%0b a_ready=%0b out_valid=%0b, required 01/0/0/1",
                         i, owner, sel, a_ready, out_valid);
            end
            next_cycle();
        end
        // Two transfers already counted: two more A words, then B
        out_ready = 1'b1;
        exp_q.push_back(1'b0); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
        for (int i = 0; i < 3; i++) next_cycle();
        checks++;
        if (exp_q.size() != 0 || owner !== 2'b10) begin
            errors++;
            $display("FAIL stall_resume: got %0d pending owner=%0b, required 0/10", exp_q.size(), owner);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (owner !== 2'b00 || out_valid !== 1'b0 || b_ready !== 1'b0 || sel !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_burst: got owner=%0b out_valid=%0b b_ready=%0b sel=%0b, required 0/0/0/0",
                     owner, out_valid, b_ready, sel);
        end
    endtask

    task automatic test_drop_valid();
        do_reset();
        a_valid = 1'b1; out_ready = 1'b1;
        exp_q.push_back(1'b0); exp_q.push_back(1'b0);
        for (int i = 0; i < 3; i++) next_cycle();
        a_valid = 1'b0;
        next_cycle();
        checks++;
        if (owner !== 2'b00 || sel !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drop_release: got owner=%0b sel=%0b pending=%0d, required 00/0/0", owner, sel, exp_q.size());
        end
        b_valid = 1'b1; out_ready = 1'b0;
        next_cycle();
        checks++;
        if (owner !== 2'b10 || sel !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL drop_then_b: got owner=%0b sel=%0b out_valid=%0b, required 10/1/1", owner, sel, out_valid);
        end
        b_valid = 1'b0;
    endtask

    task automatic test_stats();
        int start_a, start_b;
        do_reset();
        start_a = n_a; start_b = n_b;
        a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 24; i++) exp_q.push_back(((i / 4) % 2) == 1);
        for (int i = 0; i <= 24; i++) next_cycle();
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || n_a - start_a != 12 || n_b - start_b != 12) begin
            errors++;
            $display("FAIL stats_traffic: got a=%0d b=%0d pending=%0d, required 12/12/0",
                     n_a - start_a, n_b - start_b, exp_q.size());
        end
        checks++;
        if (xfer_cnt_a !== EXP_STAT || xfer_cnt_b !== EXP_STAT) begin
            errors++;
            $display("FAIL stats_counters: got a=%0d b=%0d, required %0d/%0d", xfer_cnt_a, xfer_cnt_b, EXP_STAT, EXP_STAT);
        end
        next_cycle();
    endtask

    initial begin
        rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
        #1;
        test_reset();
        test_single_owner();
        test_round_robin();
        test_stall();
        test_drop_valid();
        test_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
